// File: rtl/xeng_int_sched.sv
// Integration scheduler for the X-engine correlator: counts baselines/channels/spectra,
// flags first/last spectrum, swaps the accumulator double buffer and requests readout dumps.
module xeng_int_sched #(
  parameter int unsigned N_ANTS    = 8,
  parameter int unsigned N_CHANS   = 128,
  parameter int unsigned ACC_LEN   = 1024,
  parameter int unsigned INT_CNT_W = 32,
  localparam int unsigned N_BLS    = N_ANTS * (N_ANTS + 1) / 2,
  localparam int unsigned BL_W     = (N_BLS > 1) ? $clog2(N_BLS) : 1,
  localparam int unsigned CHAN_W   = (N_CHANS > 1) ? $clog2(N_CHANS) : 1,
  localparam int unsigned SPEC_W   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 sync,
  input  logic                 din_vld,
  input  logic                 dump_ack,
  input  logic                 err_clr,
  output logic                 bl_sync,
  output logic                 bl_en,
  output logic                 acc_first,
  output logic                 acc_last,
  output logic [CHAN_W-1:0]    chan_idx,
  output logic                 buf_sel,
  output logic                 dump_req,
  output logic [INT_CNT_W-1:0] int_cnt,
  output logic                 ovf_err,
  output logic                 sync_err,
  output logic                 running
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state, state_d;
  logic [BL_W-1:0]        bl_cnt, bl_cnt_d;
  logic [CHAN_W-1:0]      chan_cnt, chan_cnt_d;
  logic [SPEC_W-1:0]      spec_cnt, spec_cnt_d;
  logic                   bl_sync_d, bl_en_d, acc_first_d, acc_last_d;
  logic [CHAN_W-1:0]      chan_idx_d;
  logic                   buf_sel_d, dump_req_d, ovf_err_d, sync_err_d, running_d;
  logic [INT_CNT_W-1:0]   int_cnt_d;
  logic                   int_end, ovf_set, sync_err_set;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    bl_cnt_d     = bl_cnt;
    chan_cnt_d   = chan_cnt;
    spec_cnt_d   = spec_cnt;
    bl_sync_d    = 1'b0;
    bl_en_d      = 1'b0;
    acc_first_d  = 1'b0;
    acc_last_d   = 1'b0;
    chan_idx_d   = chan_idx;
    int_end      = 1'b0;
    sync_err_set = 1'b0;

    case (state)
      S_IDLE: begin
        if (arm && sync) begin
          state_d    = S_RUN;
          bl_sync_d  = 1'b1;
          bl_cnt_d   = '0;
          chan_cnt_d = '0;
          spec_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (sync) begin
          // A sync that does not land on an integration boundary discards the partial integration
          bl_sync_d    = 1'b1;
          sync_err_set = (bl_cnt != '0) || (chan_cnt != '0) || (spec_cnt != '0);
          bl_cnt_d     = '0;
          chan_cnt_d   = '0;
          spec_cnt_d   = '0;
        end else if (din_vld) begin
          bl_en_d     = 1'b1;
          acc_first_d = (spec_cnt == '0);
          acc_last_d  = (spec_cnt == SPEC_W'(ACC_LEN - 1));
          chan_idx_d  = chan_cnt;
          if (bl_cnt == BL_W'(N_BLS - 1)) begin
            bl_cnt_d = '0;
            if (chan_cnt == CHAN_W'(N_CHANS - 1)) begin
              chan_cnt_d = '0;
              if (spec_cnt == SPEC_W'(ACC_LEN - 1)) begin
                spec_cnt_d = '0;
                int_end    = 1'b1;
                if (!arm) state_d = S_IDLE;
              end else begin
                spec_cnt_d = spec_cnt + SPEC_W'(1);
              end
            end else begin
              chan_cnt_d = chan_cnt + CHAN_W'(1);
            end
          end else begin
            bl_cnt_d = bl_cnt + BL_W'(1);
          end
        end
      end
    endcase

    // Buffer swap and readout handshake; end-of-integration beats a same-cycle ack
    buf_sel_d  = buf_sel ^ int_end;
    int_cnt_d  = int_end ? int_cnt + INT_CNT_W'(1) : int_cnt;
    ovf_set    = int_end && dump_req && !dump_ack;
    dump_req_d = int_end ? 1'b1 : (dump_ack ? 1'b0 : dump_req);
    ovf_err_d  = ovf_set || (ovf_err && !err_clr);
    sync_err_d = sync_err_set || (sync_err && !err_clr);
    running_d  = (state_d == S_RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bl_cnt    <= '0;
      chan_cnt  <= '0;
      spec_cnt  <= '0;
      bl_sync   <= 1'b0;
      bl_en     <= 1'b0;
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
      chan_idx  <= '0;
      buf_sel   <= 1'b0;
      dump_req  <= 1'b0;
      int_cnt   <= '0;
      ovf_err   <= 1'b0;
      sync_err  <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_d;
      bl_cnt    <= bl_cnt_d;
      chan_cnt  <= chan_cnt_d;
      spec_cnt  <= spec_cnt_d;
      bl_sync   <= bl_sync_d;
      bl_en     <= bl_en_d;
      acc_first <= acc_first_d;
      acc_last  <= acc_last_d;
      chan_idx  <= chan_idx_d;
      buf_sel   <= buf_sel_d;
      dump_req  <= dump_req_d;
      int_cnt   <= int_cnt_d;
      ovf_err   <= ovf_err_d;
      sync_err  <= sync_err_d;
      running   <= running_d;
    end
  end

endmodule
